skolem_sweep_checker: RTL and testbench

Sequential self-check stage for the 4-bit `find_inv_bvsge_bvneg` Skolem function.

- Drives every value of the free input t onto an externally instantiated Skolem function, one value at a time.
- Captures the witness x it returns and checks the invertibility condition bvsge(bvneg(x), t).
- Reports a pass/fail summary plus the first counterexample.
- Sits directly around the Skolem block: it produces that block's inputs and consumes its outputs. This is how synthesized Skolem netlists are signed off in hardware or in simulation.

---
 rtl/skolem_sweep_checker_pkg.sv | 28 ++
 rtl/skolem_sweep_checker_if.sv | 17 +
 rtl/skolem_sweep_checker_cmp.sv | 12 +
 rtl/skolem_sweep_checker.sv | 112 +++++++++++
 tb/tb_skolem_sweep_checker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/skolem_sweep_checker_pkg.sv
// Shared types and helpers for the Skolem sweep checker: FSM state encoding,
// default width and the negate-and-signed-compare pass function.
package skolem_chk_pkg;

   localparam int SKC_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } skc_state_t;

   // Operands arrive zero-extended; shifting up by (32-w) and back down
   // arithmetically both wraps the negation at w bits and sign-extends it.
   function automatic logic sge_neg(input logic [31:0] x, input logic [31:0] t, input int w);
      logic        [31:0] neg;
      logic signed [31:0] sn;
      logic signed [31:0] st;
      int                 sh;
      sh  = 32 - w;
      neg = ~x + 32'd1;
      sn  = $signed(neg << sh) >>> sh;
      st  = $signed(t << sh) >>> sh;
      return sn >= st;
   endfunction

endpackage

// File: rtl/skolem_sweep_checker_if.sv
// Control/result bus of the sweep checker: start request in, sweep status
// and first-counterexample report out.
interface skolem_sweep_checker_if #(parameter int WIDTH = 4);
   logic             start;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH:0]   fail_cnt;
   logic             first_fail_vld;
   logic [WIDTH-1:0] first_fail_t;
   logic [WIDTH-1:0] first_fail_x;

   modport master (output start, input busy, done, pass, fail_cnt,
                   first_fail_vld, first_fail_t, first_fail_x);
   modport slave  (input start, output busy, done, pass, fail_cnt,
                   first_fail_vld, first_fail_t, first_fail_x);
endinterface

// File: rtl/skolem_sweep_checker_cmp.sv
// Combinational invertibility check: ok = bvsge(bvneg(x), t) at WIDTH bits.
module skc_sge_neg_cmp
   import skolem_chk_pkg::*;
#(
   parameter int WIDTH = SKC_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] t,
   output logic             ok
);
   assign ok = sge_neg(32'(x), 32'(t), WIDTH);
endmodule

// File: rtl/skolem_sweep_checker.sv
// Sweeps every t through an external Skolem function and checks its witness.
// Optional macro SKC_STOP_ON_FAIL_EN ends the sweep at the first failure.
module skolem_sweep_checker
   import skolem_chk_pkg::*;
#(
   parameter int WIDTH  = SKC_WIDTH,
   parameter int SETTLE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic [WIDTH-1:0]        t_o,
   input  logic [WIDTH-1:0]        x_i,
   skolem_sweep_checker_if.slave   bus
);
   localparam int               SCW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0]   SETTLE_LD = SCW'(SETTLE - 1);

   skc_state_t       state;
   logic [SCW-1:0]   settle_cnt;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH:0]   fail_cnt;
   logic             ff_vld;
   logic [WIDTH-1:0] ff_t;
   logic [WIDTH-1:0] ff_x;

   logic             ok;
   logic             last_t;
   logic             stop;
   logic [WIDTH:0]   fail_cnt_nxt;

   skc_sge_neg_cmp #(.WIDTH(WIDTH)) u_cmp (
      .x  (x_i),
      .t  (t_o),
      .ok (ok)
   );

   assign last_t       = (t_o == {WIDTH{1'b1}});
   assign fail_cnt_nxt = fail_cnt + {{WIDTH{1'b0}}, ~ok};
`ifdef SKC_STOP_ON_FAIL_EN
   assign stop = ~ok;
`else
   assign stop = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         settle_cnt <= '0;
         t_o        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_cnt   <= '0;
         ff_vld     <= 1'b0;
         ff_t       <= '0;
         ff_x       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state      <= HOLD;
                  settle_cnt <= SETTLE_LD;
                  t_o        <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  fail_cnt   <= '0;
                  ff_vld     <= 1'b0;
                  ff_t       <= '0;
                  ff_x       <= '0;
               end
            end
            HOLD: begin
               if (settle_cnt == '0) state <= CHECK;
               else                  settle_cnt <= settle_cnt - 1'b1;
            end
            CHECK: begin
               fail_cnt <= fail_cnt_nxt;
               if (!ok && !ff_vld) begin
                  ff_vld <= 1'b1;
                  ff_t   <= t_o;
                  ff_x   <= x_i;
               end
               // t_o is left on the last checked value so it reads back after the sweep
               if (last_t || stop) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_cnt_nxt == '0);
               end else begin
                  state      <= HOLD;
                  settle_cnt <= SETTLE_LD;
                  t_o        <= t_o + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy           = busy;
   assign bus.done           = done;
   assign bus.pass           = pass;
   assign bus.fail_cnt       = fail_cnt;
   assign bus.first_fail_vld = ff_vld;
   assign bus.first_fail_t   = ff_t;
   assign bus.first_fail_x   = ff_x;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Bench for skolem_sweep_checker: timeline/result model checked every cycle,
// plus literal expectations for the directed sweeps.
module tb_skolem_sweep_checker;
   import skolem_chk_pkg::*;

   localparam int W = 4;
   localparam int S = 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] t_o, x_i, t2, x2;
   logic [W-1:0] x_const = '0;
   logic [W-1:0] d1, d2;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   skolem_sweep_checker_if #(.WIDTH(W)) bus ();
   skolem_sweep_checker_if #(.WIDTH(W)) bus2 ();

   assign x_i = x_const;

   skolem_sweep_checker #(.WIDTH(W), .SETTLE(S)) dut (
      .clk (clk), .rst (rst), .t_o (t_o), .x_i (x_i), .bus (bus)
   );

   // Second instance: witness comes back through two register stages
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         d1 <= '0;
         d2 <= '0;
      end else begin
         d1 <= 4'b1001;
         d2 <= d1;
      end
   end
   assign x2 = d2;

   skolem_sweep_checker #(.WIDTH(W), .SETTLE(3)) dut2 (
      .clk (clk), .rst (rst), .t_o (t2), .x_i (x2), .bus (bus2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Whole-sweep outcome for a constant witness, from the arithmetic definition
   task automatic model_sweep(input int xc, output int fc, output bit fv,
                              output int ft, output int fx, output int last);
      int neg, sn, st;
      fc = 0; fv = 0; ft = 0; fx = 0; last = (1 << W) - 1;
      neg = ((1 << W) - xc) % (1 << W);
      sn  = (neg >= (1 << (W-1))) ? neg - (1 << W) : neg;
      for (int t = 0; t < (1 << W); t++) begin
         st = (t >= (1 << (W-1))) ? t - (1 << W) : t;
         if (sn < st) begin
            fc++;
            if (!fv) begin
               fv = 1; ft = t; fx = xc;
            end
`ifdef SKC_STOP_ON_FAIL_EN
            last = t;
            break;
`endif
         end
      end
   endtask

   int m_cnt = 0, m_lat = 0;
   int p_fc, p_ft, p_fx, p_last;
   bit p_fv;
   int e_fc = 0, e_ft = 0, e_fx = 0, e_t = 0;
   bit e_fv = 0, e_pass = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; e_fc = 0; e_fv = 0; e_ft = 0; e_fx = 0; e_pass = 0; e_t = 0;
      end else if (m_cnt == 0) begin
         if (bus.start) begin
            m_cnt = 1; e_fc = 0; e_fv = 0; e_ft = 0; e_fx = 0; e_pass = 0; e_t = 0;
            model_sweep(int'(x_const), p_fc, p_fv, p_ft, p_fx, p_last);
            m_lat = (p_last + 1) * (S + 1) + 1;
         end
      end else if (m_cnt == m_lat) begin
         m_cnt = 0;
      end else begin
         m_cnt++;
         if (m_cnt == m_lat) begin
            e_fc = p_fc; e_fv = p_fv; e_ft = p_ft; e_fx = p_fx;
            e_pass = (p_fc == 0); e_t = p_last;
         end else begin
            e_t = (m_cnt - 1) / (S + 1);
         end
      end
   end

   always @(negedge clk) begin
      bit e_busy, e_done;
      e_busy = (m_cnt >= 1) && (m_cnt < m_lat);
      e_done = (m_cnt != 0) && (m_cnt == m_lat);
      if (bus.done) done_cnt++;
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("t_o", 32'(t_o), e_t);
      if (!e_busy) begin
         chk("fail_cnt", 32'(bus.fail_cnt), e_fc);
         chk("pass", 32'(bus.pass), 32'(e_pass));
         chk("first_fail_vld", 32'(bus.first_fail_vld), 32'(e_fv));
         chk("first_fail_t", 32'(bus.first_fail_t), e_ft);
         chk("first_fail_x", 32'(bus.first_fail_x), e_fx);
      end
   end

   task automatic run_sweep(input logic [W-1:0] xc, output int lat);
      @(posedge clk); #1;
      x_const   = xc;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat, fc, ft, fx, last, dc0, bcnt;
      bit fv;
      bus.start  = 1'b0;
      bus2.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_fail_cnt", 32'(bus.fail_cnt), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_t_o", 32'(t_o), 0);

      model_sweep(0, fc, fv, ft, fx, last);
`ifdef SKC_STOP_ON_FAIL_EN
      chk("model_x0_fc", fc, 1);
`else
      chk("model_x0_fc", fc, 7);
`endif
      chk("model_x0_ft", ft, 1);
      model_sweep(8, fc, fv, ft, fx, last);
`ifndef SKC_STOP_ON_FAIL_EN
      chk("model_x8_fc", fc, 15);
`endif
      chk("model_x8_ft", ft, 0);

      run_sweep(4'b1001, lat);
      chk("x1001_lat", lat, 33);
      chk("x1001_pass", 32'(bus.pass), 1);
      chk("x1001_fail_cnt", 32'(bus.fail_cnt), 0);
      chk("x1001_ffv", 32'(bus.first_fail_vld), 0);

      run_sweep(4'b0000, lat);
`ifdef SKC_STOP_ON_FAIL_EN
      chk("x0000_lat", lat, 5);
      chk("x0000_fail_cnt", 32'(bus.fail_cnt), 1);
      chk("x0000_t_o", 32'(t_o), 1);
`else
      chk("x0000_lat", lat, 33);
      chk("x0000_fail_cnt", 32'(bus.fail_cnt), 7);
`endif
      chk("x0000_ff_t", 32'(bus.first_fail_t), 1);
      chk("x0000_ff_x", 32'(bus.first_fail_x), 0);
      chk("x0000_pass", 32'(bus.pass), 0);

      run_sweep(4'b1000, lat);
`ifndef SKC_STOP_ON_FAIL_EN
      chk("x1000_fail_cnt", 32'(bus.fail_cnt), 15);
`endif
      chk("x1000_ff_t", 32'(bus.first_fail_t), 0);
      chk("x1000_ff_x", 32'(bus.first_fail_x), 8);
      chk("x1000_pass", 32'(bus.pass), 0);

      // start during busy must be dropped
      dc0 = done_cnt;
      x_const   = 4'b1001;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         bus.start = (lat == 10);
      end
      bus.start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("ignore_lat", lat, 33);
      chk("ignore_done_cnt", done_cnt - dc0, 1);
      chk("ignore_busy", 32'(bus.busy), 0);

      // reset mid-sweep
      dc0 = done_cnt;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_t_o", 32'(t_o), 0);
      chk("midrst_pass", 32'(bus.pass), 0);
      chk("midrst_fail_cnt", 32'(bus.fail_cnt), 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt - dc0, 0);

      // SETTLE=3 instance with delayed witness
      bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      bcnt = 0;
      lat  = 1;
      while (!bus2.done && lat < 300) begin
         if (bus2.busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      chk("s3_busy_cycles", bcnt, 64);
      chk("s3_done", 32'(bus2.done), 1);
      chk("s3_pass", 32'(bus2.pass), 1);
      chk("s3_fail_cnt", 32'(bus2.fail_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
